// File: rtl/reservation_station_pkg.sv
// Shared widths, entry layout and CDB snoop helper for the reservation station.
// Optional feature macro: RS_AGE_ORDER_EN (oldest-ready issue instead of lowest index).
package reservation_station_pkg;

  localparam int IDWidth          = 32;
  localparam int ROBWidth         = 4;
  localparam int AddressWidth     = 32;
  localparam int InstTypeWidth    = 6;
  localparam int RS_DEPTH_DEFAULT = 8;

  localparam logic [ROBWidth-1:0] TAG_NONE = '0;

  typedef enum logic [InstTypeWidth-1:0] {
    OP_NOP = 6'd0,
    OP_ADD = 6'd1,
    OP_SUB = 6'd2,
    OP_AND = 6'd3,
    OP_OR  = 6'd4
  } inst_type_e;

  typedef struct packed {
    logic [IDWidth-1:0]  v;
    logic [ROBWidth-1:0] q;
  } operand_t;

  typedef struct packed {
    logic [InstTypeWidth-1:0] opcode;
    logic [IDWidth-1:0]       vj;
    logic [ROBWidth-1:0]      qj;
    logic [IDWidth-1:0]       vk;
    logic [ROBWidth-1:0]      qk;
    logic [IDWidth-1:0]       a;
    logic [AddressWidth-1:0]  pc;
    logic [ROBWidth-1:0]      dest;
  } rs_entry_t;

  // Resolve a waiting operand against both CDBs; the ALU bus wins a tag tie.
  function automatic operand_t snoop(
    input logic [ROBWidth-1:0] q,
    input logic [IDWidth-1:0]  v,
    input logic                alu_en,
    input logic [ROBWidth-1:0] alu_tag,
    input logic [IDWidth-1:0]  alu_value,
    input logic                lsb_en,
    input logic [ROBWidth-1:0] lsb_tag,
    input logic [IDWidth-1:0]  lsb_value
  );
    operand_t r;
    r.q = q;
    r.v = v;
    if (q != TAG_NONE) begin
      if (alu_en && q == alu_tag) begin
        r.v = alu_value;
        r.q = TAG_NONE;
      end else if (lsb_en && q == lsb_tag) begin
        r.v = lsb_value;
        r.q = TAG_NONE;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/reservation_station_issue_select.sv
// Picks the entry to issue (lowest index, or oldest ready with RS_AGE_ORDER_EN)
// and the lowest-index free slot for dispatch.
module rs_issue_select
  import reservation_station_pkg::*;
#(
  parameter int DEPTH = RS_DEPTH_DEFAULT,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0]             ready_vec,
`ifdef RS_AGE_ORDER_EN
  input  logic [DEPTH-1:0][DEPTH-1:0]  age,
`endif
  input  logic [DEPTH-1:0]             free_vec,
  output logic                         issue_valid,
  output logic [IDX_W-1:0]             issue_idx,
  output logic                         free_valid,
  output logic [IDX_W-1:0]             free_idx
);

  logic [DEPTH-1:0] candidates;

  // Under age ordering only a ready entry with no older ready entry survives.
  always_comb begin
    candidates = ready_vec;
`ifdef RS_AGE_ORDER_EN
    for (int i = 0; i < DEPTH; i++) begin
      candidates[i] = ready_vec[i] && ((age[i] & ready_vec) == '0);
    end
`endif
  end

  always_comb begin
    issue_valid = |candidates;
    issue_idx   = '0;
    free_valid  = |free_vec;
    free_idx    = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (candidates[i]) issue_idx = IDX_W'(i);
      if (free_vec[i])   free_idx  = IDX_W'(i);
    end
  end

endmodule

// File: rtl/reservation_station.sv
// Out-of-order issue buffer between dispatcher and ALU with dual-CDB wake-up.
// Optional feature macro: RS_AGE_ORDER_EN (age-matrix oldest-first issue).
module reservation_station
  import reservation_station_pkg::*;
#(
  parameter int RS_DEPTH = RS_DEPTH_DEFAULT
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     rdy_in,
  input  logic                     dispatcher_rs_en_in,
  input  logic [InstTypeWidth-1:0] dispatcher_rs_opcode_in,
  input  logic [IDWidth-1:0]       dispatcher_rs_vj_in,
  input  logic [IDWidth-1:0]       dispatcher_rs_vk_in,
  input  logic [ROBWidth-1:0]      dispatcher_rs_qj_in,
  input  logic [ROBWidth-1:0]      dispatcher_rs_qk_in,
  input  logic [IDWidth-1:0]       dispatcher_rs_a_in,
  input  logic [AddressWidth-1:0]  dispatcher_rs_pc_in,
  input  logic [ROBWidth-1:0]      dispatcher_rs_dest_in,
  output logic                     rs_full_out,
  input  logic                     alu_cdb_en_in,
  input  logic [ROBWidth-1:0]      alu_cdb_tag_in,
  input  logic [IDWidth-1:0]       alu_cdb_value_in,
  input  logic                     lsb_cdb_en_in,
  input  logic [ROBWidth-1:0]      lsb_cdb_tag_in,
  input  logic [IDWidth-1:0]       lsb_cdb_value_in,
  input  logic                     rob_rs_clear_in,
  output logic                     rs_alu_en_out,
  output logic [InstTypeWidth-1:0] rs_alu_opcode_out,
  output logic [IDWidth-1:0]       rs_alu_vj_out,
  output logic [IDWidth-1:0]       rs_alu_vk_out,
  output logic [IDWidth-1:0]       rs_alu_a_out,
  output logic [AddressWidth-1:0]  rs_alu_pc_out,
  output logic [ROBWidth-1:0]      rs_alu_dest_out
);

  localparam int IDX_W = $clog2(RS_DEPTH);

  rs_entry_t           entries [RS_DEPTH];
  logic [RS_DEPTH-1:0] busy;
  logic [RS_DEPTH-1:0] ready_vec;
  operand_t            wake_j [RS_DEPTH];
  operand_t            wake_k [RS_DEPTH];
  operand_t            disp_j;
  operand_t            disp_k;
  logic                issue_valid;
  logic [IDX_W-1:0]    issue_idx;
  logic                free_valid;
  logic [IDX_W-1:0]    free_idx;
`ifdef RS_AGE_ORDER_EN
  logic [RS_DEPTH-1:0][RS_DEPTH-1:0] age;
`endif

  // Readiness and wake-up are both derived from stored state, so a broadcast
  // wakes an entry on its edge and issue follows no earlier than the next one.
  always_comb begin
    for (int i = 0; i < RS_DEPTH; i++) begin
      ready_vec[i] = busy[i] && entries[i].qj == TAG_NONE && entries[i].qk == TAG_NONE;
      wake_j[i] = snoop(entries[i].qj, entries[i].vj, alu_cdb_en_in, alu_cdb_tag_in,
                        alu_cdb_value_in, lsb_cdb_en_in, lsb_cdb_tag_in, lsb_cdb_value_in);
      wake_k[i] = snoop(entries[i].qk, entries[i].vk, alu_cdb_en_in, alu_cdb_tag_in,
                        alu_cdb_value_in, lsb_cdb_en_in, lsb_cdb_tag_in, lsb_cdb_value_in);
    end
  end

  assign disp_j = snoop(dispatcher_rs_qj_in, dispatcher_rs_vj_in, alu_cdb_en_in, alu_cdb_tag_in,
                        alu_cdb_value_in, lsb_cdb_en_in, lsb_cdb_tag_in, lsb_cdb_value_in);
  assign disp_k = snoop(dispatcher_rs_qk_in, dispatcher_rs_vk_in, alu_cdb_en_in, alu_cdb_tag_in,
                        alu_cdb_value_in, lsb_cdb_en_in, lsb_cdb_tag_in, lsb_cdb_value_in);

  // Two-entry threshold leaves room for a dispatch already in flight.
  assign rs_full_out = ($countones(~busy) < 2);

  rs_issue_select #(.DEPTH(RS_DEPTH), .IDX_W(IDX_W)) u_select (
    .ready_vec   (ready_vec),
`ifdef RS_AGE_ORDER_EN
    .age         (age),
`endif
    .free_vec    (~busy),
    .issue_valid (issue_valid),
    .issue_idx   (issue_idx),
    .free_valid  (free_valid),
    .free_idx    (free_idx)
  );

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      busy              <= '0;
      rs_alu_en_out     <= 1'b0;
      rs_alu_opcode_out <= '0;
      rs_alu_vj_out     <= '0;
      rs_alu_vk_out     <= '0;
      rs_alu_a_out      <= '0;
      rs_alu_pc_out     <= '0;
      rs_alu_dest_out   <= '0;
`ifdef RS_AGE_ORDER_EN
      age               <= '0;
`endif
    end else if (rdy_in) begin
      if (rob_rs_clear_in) begin
        busy          <= '0;
        rs_alu_en_out <= 1'b0;
      end else begin
        for (int i = 0; i < RS_DEPTH; i++) begin
          if (busy[i]) begin
            entries[i].vj <= wake_j[i].v;
            entries[i].qj <= wake_j[i].q;
            entries[i].vk <= wake_k[i].v;
            entries[i].qk <= wake_k[i].q;
          end
        end
        rs_alu_en_out <= issue_valid;
        if (issue_valid) begin
          busy[issue_idx]   <= 1'b0;
          rs_alu_opcode_out <= entries[issue_idx].opcode;
          rs_alu_vj_out     <= entries[issue_idx].vj;
          rs_alu_vk_out     <= entries[issue_idx].vk;
          rs_alu_a_out      <= entries[issue_idx].a;
          rs_alu_pc_out     <= entries[issue_idx].pc;
          rs_alu_dest_out   <= entries[issue_idx].dest;
        end
        // The slot chosen here was free before this edge, so it never collides with issue.
        if (dispatcher_rs_en_in && free_valid) begin
          busy[free_idx]           <= 1'b1;
          entries[free_idx].opcode <= dispatcher_rs_opcode_in;
          entries[free_idx].vj     <= disp_j.v;
          entries[free_idx].qj     <= disp_j.q;
          entries[free_idx].vk     <= disp_k.v;
          entries[free_idx].qk     <= disp_k.q;
          entries[free_idx].a      <= dispatcher_rs_a_in;
          entries[free_idx].pc     <= dispatcher_rs_pc_in;
          entries[free_idx].dest   <= dispatcher_rs_dest_in;
`ifdef RS_AGE_ORDER_EN
          for (int k = 0; k < RS_DEPTH; k++) begin
            age[k][free_idx] <= 1'b0;
          end
          age[free_idx] <= busy;
`endif
        end
      end
    end
  end

  dispatch_overflow: assert property (@(posedge clk_in) disable iff (!rst_in)
    !(rdy_in && !rob_rs_clear_in && dispatcher_rs_en_in && !free_valid));

endmodule
